uart_tx_buffered: RTL and testbench
===================================

Name: uart_tx_buffered

Overview:
- UART transmitter: serialises bytes onto one TX line as 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit).
- A small synchronous FIFO sits in front of the transmitter, so a host can queue several bytes without waiting for each frame to finish.
- Counterpart of the UART receive path; drives the board's serial TX pin. Fed by test logic or a future command/echo block.

Parameters:
- CLKS_PER_BIT, 217, clock cycles per serial bit (25 MHz / 115200 baud); must be >= 2.
- FIFO_DEPTH, 4, number of queued bytes; power of two, >= 2.

Ports:
- i_Clk  input  1  system clock; all logic is on the rising edge.
- i_Rst_L  input  1  asynchronous, active-low reset.
- i_TX_DV  input  1  write strobe; i_TX_Byte is sampled on every edge where this is high.
- i_TX_Byte  input  8  byte to queue.
- o_TX_Ready  output  1  FIFO not full; a write is accepted only when this is high.
- o_TX_Overflow  output  1  one-cycle pulse when i_TX_DV is high while o_TX_Ready is low (byte dropped).
- o_TX_Serial  output  1  serial line; idles high.
- o_TX_Active  output  1  high while a frame is on the line (START through STOP).
- o_TX_Done  output  1  one-cycle pulse in the last cycle of each stop bit.
- o_Fifo_Count  output  $clog2(FIFO_DEPTH)+1  number of bytes currently queued (not counting the byte being shifted).

Behaviour:
- Reset (async assert, sync release):
  - o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0, o_TX_Overflow=0, o_TX_Ready=1, o_Fifo_Count=0.
  - FIFO pointers cleared; state=IDLE; bit counter=0; baud counter=0.
  - Reset mid-frame aborts the frame immediately and drives the line high. Queued bytes are lost.
- FIFO:
  - Push when i_TX_DV & o_TX_Ready. Pop when the FSM loads a byte.
  - Simultaneous push and pop: count unchanged, both take effect.
  - A push while full is dropped even if a pop happens in the same cycle, because o_TX_Ready is registered from the count. o_TX_Overflow pulses on that cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - Count updates on the edge after the push/pop.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE:
    - o_TX_Serial=1, o_TX_Active=0.
    - If count>0: pop the head into the shift register and go to START.
  - START:
    - o_TX_Serial=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA:
    - o_TX_Serial = shift_reg[bit index], held CLKS_PER_BIT cycles per bit.
    - Index increments 0..7. After bit 7, go to STOP.
  - STOP:
    - o_TX_Serial=1 for CLKS_PER_BIT cycles. o_TX_Done=1 in the final cycle.
    - In that final cycle, if count>0: pop and go directly to START (back-to-back frames, no idle gap). Otherwise go to IDLE.
- o_TX_Active=1 in START, DATA and STOP.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and resets to 0 on every bit boundary and on every state change.
  - Counter width is $clog2(CLKS_PER_BIT).
- Latency:
  - A push at edge n gives count>0 at edge n+1.
  - IDLE pops at that edge, so o_TX_Serial falls at edge n+2.
- Frame length: exactly 10*CLKS_PER_BIT cycles from start-bit falling edge to end of stop bit.
- Bytes are transmitted in push order. The byte is latched at pop, so later pushes never corrupt the frame in flight.
- All outputs are registered; o_TX_Serial has no glitches.

Test Plan:
1. Reset then idle, CLKS_PER_BIT=4, FIFO_DEPTH=4 → o_TX_Serial=1, o_TX_Ready=1, o_Fifo_Count=0, o_TX_Active=0 for 50 cycles.
2. Push 0xA5 at edge n:
   - o_TX_Serial falls at n+2.
   - Line shows 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles wide.
   - o_TX_Done pulses once at cycle n+41; then IDLE.
3. Push 0x01,0x02,0x03 on consecutive cycles:
   - o_Fifo_Count peaks at 2 (one byte already popped).
   - Three frames back-to-back with no high gap beyond the stop bits; o_TX_Done pulses 3 times, 40 cycles apart.
4. Fill while transmitting, 6 consecutive pushes 0x10..0x15:
   - Byte 0x10 is popped immediately; 0x11..0x14 fill the FIFO; o_TX_Ready goes low.
   - 0x15 is dropped with a one-cycle o_TX_Overflow pulse.
   - Received sequence is 0x10..0x14.
5. Assert i_Rst_L=0 mid-DATA of frame 0xFF with 2 bytes queued:
   - o_TX_Serial=1 and o_TX_Active=0 immediately (same cycle, asynchronously).
   - o_Fifo_Count=0; nothing is transmitted after release.
6. Push exactly in the final STOP cycle with an empty FIFO:
   - FSM goes to IDLE, then pops next cycle; start bit begins 2 cycles after the push.
   - Push one cycle earlier instead: frame starts directly after the stop bit.

Source files
------------

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter fronted by a small FIFO so the host can queue bytes while a frame is
// in flight. Back-to-back queued bytes go out with no idle gap between stop and start bits.
module uart_tx_buffered #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst_L,
  input  logic                          i_TX_DV,
  input  logic [7:0]                    i_TX_Byte,
  output logic                          o_TX_Ready,
  output logic                          o_TX_Overflow,
  output logic                          o_TX_Serial,
  output logic                          o_TX_Active,
  output logic                          o_TX_Done,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);

  localparam int unsigned CntW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CountW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e            state_q;
  logic [CntW-1:0]   baud_q;
  logic [2:0]        bit_idx_q;
  logic [7:0]        shift_q;
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CountW-1:0] count_d;

  logic push, pop, baud_last, fifo_nonempty;
  logic [2:0] bit_idx_next;

  assign push          = i_TX_DV & o_TX_Ready;
  assign fifo_nonempty = (o_Fifo_Count != '0);
  assign baud_last     = (baud_q == CntW'(CLKS_PER_BIT - 1));
  assign bit_idx_next  = bit_idx_q + 3'd1;
  // The FSM latches the head byte either from idle or in the final stop cycle.
  assign pop = fifo_nonempty &
               ((state_q == StIdle) | ((state_q == StStop) & baud_last));

  always_comb begin
    count_d = o_Fifo_Count;
    unique case ({push, pop})
      2'b10:   count_d = o_Fifo_Count + CountW'(1);
      2'b01:   count_d = o_Fifo_Count - CountW'(1);
      default: count_d = o_Fifo_Count;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (push) mem_q[wr_ptr_q] <= i_TX_Byte;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      o_Fifo_Count  <= '0;
      o_TX_Ready    <= 1'b1;
      o_TX_Overflow <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      o_Fifo_Count  <= count_d;
      o_TX_Ready    <= (count_d != CountW'(FIFO_DEPTH));
      o_TX_Overflow <= i_TX_DV & ~o_TX_Ready;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q     <= StIdle;
      baud_q      <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      o_TX_Serial <= 1'b1;
      o_TX_Active <= 1'b0;
      o_TX_Done   <= 1'b0;
    end else begin
      o_TX_Done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          baud_q      <= '0;
          o_TX_Serial <= 1'b1;
          o_TX_Active <= 1'b0;
          if (pop) begin
            shift_q     <= mem_q[rd_ptr_q];
            state_q     <= StStart;
            o_TX_Serial <= 1'b0;
            o_TX_Active <= 1'b1;
          end
        end
        StStart: begin
          if (baud_last) begin
            baud_q      <= '0;
            bit_idx_q   <= '0;
            o_TX_Serial <= shift_q[0];
            state_q     <= StData;
          end else begin
            baud_q <= baud_q + CntW'(1);
          end
        end
        StData: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_idx_q == 3'd7) begin
              o_TX_Serial <= 1'b1;
              state_q     <= StStop;
            end else begin
              bit_idx_q   <= bit_idx_next;
              o_TX_Serial <= shift_q[bit_idx_next];
            end
          end else begin
            baud_q <= baud_q + CntW'(1);
          end
        end
        StStop: begin
          // Registered, so raise it one cycle ahead to land on the final stop cycle.
          if (baud_q == CntW'(CLKS_PER_BIT - 2)) o_TX_Done <= 1'b1;
          if (baud_last) begin
            baud_q <= '0;
            if (pop) begin
              shift_q     <= mem_q[rd_ptr_q];
              state_q     <= StStart;
              o_TX_Serial <= 1'b0;
            end else begin
              state_q     <= StIdle;
              o_TX_Active <= 1'b0;
            end
          end else begin
            baud_q <= baud_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
module tb_uart_tx_buffered;

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic       dv = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready, ovf, ser, active, done;
  logic [2:0] count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  uart_tx_buffered #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .i_Clk         (clk),
    .i_Rst_L       (rst_l),
    .i_TX_DV       (dv),
    .i_TX_Byte     (data),
    .o_TX_Ready    (ready),
    .o_TX_Overflow (ovf),
    .o_TX_Serial   (ser),
    .o_TX_Active   (active),
    .o_TX_Done     (done),
    .o_Fifo_Count  (count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line decoder: samples each bit one cycle into its 4-cycle window.
  logic [7:0] rx_q[$];
  int         done_q[$];
  int         frame_err = 0;
  int         ovf_seen = 0;
  int         not_ready_seen = 0;
  bit         mon_busy = 0;
  int         mon_start = 0;
  logic [7:0] mon_byte = 8'h00;

  always @(negedge clk) begin
    int k;
    if (done === 1'b1) done_q.push_back(cyc);
    if (ovf === 1'b1) ovf_seen++;
    if (ready === 1'b0) not_ready_seen++;
    if (!rst_l) begin
      mon_busy = 0;
    end else if (!mon_busy) begin
      if (ser === 1'b0) begin
        mon_busy  = 1;
        mon_start = cyc;
      end
    end else begin
      k = cyc - mon_start;
      if ((k % 4 == 1) && (k / 4 >= 1) && (k / 4 <= 8)) mon_byte[k/4-1] = ser;
      if (k == 37) begin
        if (ser !== 1'b1) frame_err++;
        rx_q.push_back(mon_byte);
      end
      if (k == 39) mon_busy = 0;
    end
  end

  task automatic push_bytes(input logic [7:0] b0, input int n, input logic [7:0] step);
    logic [7:0] b;
    b = b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      dv   = 1'b1;
      data = b;
      b    = b + step;
      @(posedge clk);
      #1;
    end
    dv = 1'b0;
  endtask

  task automatic test_reset;
    rst_l = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_l = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n_checks += 4;
      if (ser !== 1'b1)    begin n_fail++; $display("FAIL reset_serial cyc=%0d got=%b exp=1", cyc, ser); end
      if (ready !== 1'b1)  begin n_fail++; $display("FAIL reset_ready cyc=%0d got=%b exp=1", cyc, ready); end
      if (count !== 3'd0)  begin n_fail++; $display("FAIL reset_count cyc=%0d got=%0d exp=0", cyc, count); end
      if (active !== 1'b0) begin n_fail++; $display("FAIL reset_active cyc=%0d got=%b exp=0", cyc, active); end
    end
  endtask

  task automatic test_single;
    int n;
    logic [9:0] frame;
    frame = {1'b1, 8'hA5, 1'b0};
    rx_q.delete();
    done_q.delete();
    @(posedge clk);
    #1;
    dv = 1'b1;
    data = 8'hA5;
    n = cyc;
    @(posedge clk);
    #1;
    dv = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ser !== 1'b1) begin n_fail++; $display("FAIL single_pre_start got=%b exp=1", ser); end
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      n_checks += 2;
      if (ser !== frame[j/4])
        begin n_fail++; $display("FAIL single_line j=%0d got=%b exp=%b", j, ser, frame[j/4]); end
      if (done !== (j == 39))
        begin n_fail++; $display("FAIL single_done j=%0d got=%b exp=%b", j, done, (j == 39)); end
    end
    @(negedge clk);
    n_checks += 4;
    if (active !== 1'b0) begin n_fail++; $display("FAIL single_idle_active got=%b exp=0", active); end
    if (done_q.size() != 1 || done_q[0] != n + 41)
      begin n_fail++; $display("FAIL single_done_cycle got_n=%0d exp_n=1 exp_cyc=%0d", done_q.size(), n + 41); end
    if (rx_q.size() != 1) begin n_fail++; $display("FAIL single_rx_size got=%0d exp=1", rx_q.size()); end
    else if (rx_q[0] !== 8'hA5) begin n_fail++; $display("FAIL single_rx got=%h exp=a5", rx_q[0]); end
    else if (frame_err != 0) begin n_fail++; $display("FAIL single_frame_err got=%0d exp=0", frame_err); end
  endtask

  task automatic test_back_to_back;
    int peak;
    logic [7:0] exp_b;
    rx_q.delete();
    done_q.delete();
    peak = 0;
    push_bytes(8'h01, 3, 8'h01);
    for (int i = 0; i < 140; i++) begin
      @(negedge clk);
      if (int'(count) > peak) peak = int'(count);
    end
    n_checks += 4;
    if (peak != 2) begin n_fail++; $display("FAIL b2b_peak got=%0d exp=2", peak); end
    if (done_q.size() != 3) begin n_fail++; $display("FAIL b2b_done_n got=%0d exp=3", done_q.size()); end
    else if (done_q[1] - done_q[0] != 40 || done_q[2] - done_q[1] != 40)
      begin n_fail++; $display("FAIL b2b_done_gap got=%0d,%0d exp=40,40",
                               done_q[1] - done_q[0], done_q[2] - done_q[1]); end
    if (rx_q.size() != 3) begin n_fail++; $display("FAIL b2b_rx_size got=%0d exp=3", rx_q.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        exp_b = 8'(i + 1);
        n_checks++;
        if (rx_q[i] !== exp_b) begin n_fail++; $display("FAIL b2b_rx i=%0d got=%h exp=%h", i, rx_q[i], exp_b); end
      end
    end
    if (frame_err != 0) begin n_fail++; $display("FAIL b2b_frame_err got=%0d exp=0", frame_err); end
  endtask

  task automatic test_fill;
    int peak;
    logic [7:0] exp_b;
    rx_q.delete();
    ovf_seen = 0;
    not_ready_seen = 0;
    peak = 0;
    push_bytes(8'h10, 6, 8'h01);
    for (int i = 0; i < 260; i++) begin
      @(negedge clk);
      if (int'(count) > peak) peak = int'(count);
    end
    n_checks += 4;
    if (ovf_seen != 1) begin n_fail++; $display("FAIL fill_overflow_pulses got=%0d exp=1", ovf_seen); end
    if (not_ready_seen == 0) begin n_fail++; $display("FAIL fill_ready_low got=0 exp=>0"); end
    if (peak != 4) begin n_fail++; $display("FAIL fill_peak got=%0d exp=4", peak); end
    if (rx_q.size() != 5) begin n_fail++; $display("FAIL fill_rx_size got=%0d exp=5", rx_q.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        exp_b = 8'h10 + 8'(i);
        n_checks++;
        if (rx_q[i] !== exp_b) begin n_fail++; $display("FAIL fill_rx i=%0d got=%h exp=%h", i, rx_q[i], exp_b); end
      end
    end
  endtask

  task automatic test_reset_mid;
    int n;
    n = cyc + 1;
    push_bytes(8'hFF, 1, 8'h00);
    push_bytes(8'h11, 2, 8'h11);
    while (cyc < n + 14) @(negedge clk);
    n_checks += 2;
    if (active !== 1'b1) begin n_fail++; $display("FAIL mid_pre_active got=%b exp=1", active); end
    if (count !== 3'd2) begin n_fail++; $display("FAIL mid_pre_count got=%0d exp=2", count); end
    #1;
    rst_l = 1'b0;
    #1;
    n_checks += 4;
    if (ser !== 1'b1)    begin n_fail++; $display("FAIL mid_rst_serial got=%b exp=1", ser); end
    if (active !== 1'b0) begin n_fail++; $display("FAIL mid_rst_active got=%b exp=0", active); end
    if (count !== 3'd0)  begin n_fail++; $display("FAIL mid_rst_count got=%0d exp=0", count); end
    if (ready !== 1'b1)  begin n_fail++; $display("FAIL mid_rst_ready got=%b exp=1", ready); end
    @(negedge clk);
    @(negedge clk);
    rst_l = 1'b1;
    rx_q.delete();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_checks += 2;
      if (ser !== 1'b1)    begin n_fail++; $display("FAIL mid_post_serial i=%0d got=%b exp=1", i, ser); end
      if (active !== 1'b0) begin n_fail++; $display("FAIL mid_post_active i=%0d got=%b exp=0", i, active); end
    end
    n_checks++;
    if (rx_q.size() != 0) begin n_fail++; $display("FAIL mid_post_rx got=%0d exp=0", rx_q.size()); end
  endtask

  task automatic test_stop_push;
    int d;
    int budget;
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h3C;
    exp_b[1] = 8'h5A;
    exp_b[2] = 8'hC3;
    rx_q.delete();
    push_bytes(8'h3C, 1, 8'h00);
    budget = 0;
    @(negedge clk);
    while (done !== 1'b1 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL stop_wait_done got=%b exp=1", done); end
    d = cyc;
    dv = 1'b1;
    data = 8'h5A;
    @(posedge clk);
    #1;
    dv = 1'b0;
    @(negedge clk);
    n_checks += 2;
    if (ser !== 1'b1)    begin n_fail++; $display("FAIL stop_late_idle_serial got=%b exp=1", ser); end
    if (active !== 1'b0) begin n_fail++; $display("FAIL stop_late_idle_active got=%b exp=0", active); end
    @(negedge clk);
    n_checks += 2;
    if (ser !== 1'b0)    begin n_fail++; $display("FAIL stop_late_start_serial got=%b exp=0", ser); end
    if (active !== 1'b1) begin n_fail++; $display("FAIL stop_late_start_active got=%b exp=1", active); end
    while (cyc < d + 40) @(negedge clk);
    dv = 1'b1;
    data = 8'hC3;
    @(posedge clk);
    #1;
    dv = 1'b0;
    @(negedge clk);
    n_checks += 2;
    if (done !== 1'b1) begin n_fail++; $display("FAIL stop_early_done got=%b exp=1", done); end
    if (ser !== 1'b1)  begin n_fail++; $display("FAIL stop_early_stopbit got=%b exp=1", ser); end
    @(negedge clk);
    n_checks += 2;
    if (ser !== 1'b0)    begin n_fail++; $display("FAIL stop_early_start_serial got=%b exp=0", ser); end
    if (active !== 1'b1) begin n_fail++; $display("FAIL stop_early_start_active got=%b exp=1", active); end
    repeat (50) @(negedge clk);
    n_checks += 2;
    if (rx_q.size() != 3) begin n_fail++; $display("FAIL stop_rx_size got=%0d exp=3", rx_q.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (rx_q[i] !== exp_b[i]) begin n_fail++; $display("FAIL stop_rx i=%0d got=%h exp=%h", i, rx_q[i], exp_b[i]); end
      end
    end
    if (frame_err != 0) begin n_fail++; $display("FAIL stop_frame_err got=%0d exp=0", frame_err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fill();
    test_reset_mid();
    test_stop_push();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
